// File: rtl/adc_pattern_source_if.sv
// adc_pattern_source_if
//   Bundles the burst-control inputs and the frame outputs of
//   adc_pattern_source.
//   master : the pattern source (consumes START/STOP/config, drives frames)
//   slave  : the controller / capture side (drives START/STOP/config)
//   Signals:
//     START, STOP           burst handshake
//     MODE, CONST_VAL, STEP pattern configuration, latched at START
//     BURST_LEN             frames per burst (0 = continuous)
//     ADC_DATA              NUM_CH*DATA_W flat frame, channel k at [k*DATA_W +: DATA_W]
//     DATA_VLD, BUSY, DONE  frame valid, burst in progress, burst-end pulse
//     FRAME_CNT             index of the frame on ADC_DATA
interface adc_pattern_source_if #(
    parameter int NUM_CH = 96,
    parameter int DATA_W = 9
);
    logic                       START;
    logic                       STOP;
    logic [2:0]                 MODE;
    logic [DATA_W-1:0]          CONST_VAL;
    logic [DATA_W-1:0]          STEP;
    logic [15:0]                BURST_LEN;
    logic [NUM_CH*DATA_W-1:0]   ADC_DATA;
    logic                       DATA_VLD;
    logic                       BUSY;
    logic                       DONE;
    logic [15:0]                FRAME_CNT;

    modport master (
        input  START, STOP, MODE, CONST_VAL, STEP, BURST_LEN,
        output ADC_DATA, DATA_VLD, BUSY, DONE, FRAME_CNT
    );

    modport slave (
        output START, STOP, MODE, CONST_VAL, STEP, BURST_LEN,
        input  ADC_DATA, DATA_VLD, BUSY, DONE, FRAME_CNT
    );
endinterface

// File: rtl/adc_pattern_source.sv
// adc_pattern_source
//   Deterministic ADC frame generator standing in for the analog front end.
//   Emits one NUM_CH x DATA_W frame per clock during a burst, using a
//   selectable pattern (zero / constant / interleaved ramp / PRBS /
//   walking one). Bursts start on START in IDLE and end after BURST_LEN
//   frames or on STOP; DONE pulses once at the end.
//   Ports:
//     CLK500M  sample clock, rising edge
//     RST      asynchronous active-high reset
//     bus      adc_pattern_source_if.master (handshake, config, frame outputs)
module adc_pattern_source #(
    parameter int          NUM_CH    = 96,
    parameter int          DATA_W    = 9,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  CLK500M,
    input  logic                  RST,
    adc_pattern_source_if.master  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]               state;
    logic [2:0]               mode_q;
    logic [DATA_W-1:0]        const_q;
    logic [DATA_W-1:0]        step_q;
    logic [15:0]              len_q;
    // Generator state prepared for the next frame to be emitted
    logic [DATA_W-1:0]        base_q;
    logic [15:0]              lfsr_q;
    logic [4:0]               widx_q;
    logic [15:0]              frame_q;
    logic [NUM_CH*DATA_W-1:0] data_q;
    logic                     vld_q;
    logic                     busy_q;
    logic                     done_q;

    // Generator operands: live inputs in IDLE (frame 0 is built while START
    // is being accepted), latched burst state in RUN
    logic [2:0]               g_mode;
    logic [DATA_W-1:0]        g_const;
    logic [DATA_W-1:0]        g_step;
    logic [DATA_W-1:0]        g_base;
    logic [15:0]              g_lfsr;
    logic [4:0]               g_widx;
    logic [NUM_CH*DATA_W-1:0] g_frame;
    logic [DATA_W-1:0]        g_base_next;
    logic [15:0]              g_lfsr_next;
    logic [4:0]               g_widx_next;
    logic [DATA_W-1:0]        ramp;
    logic [DATA_W-1:0]        sample;
    logic [4:0]               pos;
    logic                     last_frame;

    function automatic logic [4:0] wrap_inc(input logic [4:0] p);
        return (p == 5'(DATA_W - 1)) ? 5'd0 : p + 5'd1;
    endfunction

    always_comb begin
        if (state == ST_IDLE) begin
            g_mode  = bus.MODE;
            g_const = bus.CONST_VAL;
            g_step  = bus.STEP;
            g_base  = '0;
            g_lfsr  = LFSR_SEED;
            g_widx  = '0;
        end else begin
            g_mode  = mode_q;
            g_const = const_q;
            g_step  = step_q;
            g_base  = base_q;
            g_lfsr  = lfsr_q;
            // FRAME_CNT wrapping to 0 restarts the walking-one phase so the
            // pattern stays a function of the reported frame index
            g_widx  = (frame_q == 16'hFFFF) ? 5'd0 : widx_q;
        end
    end

    always_comb begin
        g_frame = '0;
        ramp    = g_base;
        pos     = g_widx;
        sample  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            case (g_mode)
                3'd1:    sample = g_const;
                3'd2:    sample = ramp;
                3'd3:    sample = g_lfsr[DATA_W-1:0] ^ DATA_W'(k);
                3'd4:    sample = DATA_W'(1) << pos;
                default: sample = '0;
            endcase
            g_frame[k*DATA_W +: DATA_W] = sample;
            ramp = ramp + g_step;
            pos  = wrap_inc(pos);
        end
        // After NUM_CH channel steps the ramp accumulator is the next base
        g_base_next = ramp;
        g_widx_next = wrap_inc(g_widx);
        g_lfsr_next = {g_lfsr[14:0], g_lfsr[15] ^ g_lfsr[13] ^ g_lfsr[12] ^ g_lfsr[10]};
    end

    assign last_frame = (len_q != 16'd0) && (frame_q == len_q - 16'd1);

    always_ff @(posedge CLK500M or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            mode_q  <= '0;
            const_q <= '0;
            step_q  <= '0;
            len_q   <= '0;
            base_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            widx_q  <= '0;
            frame_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        state   <= ST_RUN;
                        mode_q  <= bus.MODE;
                        const_q <= bus.CONST_VAL;
                        step_q  <= bus.STEP;
                        len_q   <= bus.BURST_LEN;
                        data_q  <= g_frame;
                        frame_q <= '0;
                        vld_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        base_q  <= g_base_next;
                        lfsr_q  <= g_lfsr_next;
                        widx_q  <= g_widx_next;
                    end
                end
                ST_RUN: begin
                    if (bus.STOP || last_frame) begin
                        state  <= ST_IDLE;
                        vld_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        data_q  <= g_frame;
                        frame_q <= frame_q + 16'd1;
                        base_q  <= g_base_next;
                        lfsr_q  <= g_lfsr_next;
                        widx_q  <= g_widx_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ADC_DATA  = data_q;
    assign bus.DATA_VLD  = vld_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.FRAME_CNT = frame_q;

endmodule
